// File: rtl/regfile_pkg.sv
// ============================================================================
// Package : regfile_pkg
// Brief   : Shared sizes and FSM state encoding for the register-file
//           write-back scheduler.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int RADDR_W  = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : One-hot round-robin arbiter; the search starts at the pointer and
//          the pointer moves just past the winner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] w_idx;
    logic               w_found;

    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && en && req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_idx   = c_ptr_w'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (w_found) begin
            grant[w_idx] = 1'b1;
        end
    end

    // Pointer holds when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_idx == c_ptr_w'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_sched.sv
// ============================================================================
// Module : regfile_wb_sched
// Brief  : Write-back scheduler for the 32x32 register file: zero-fill after
//          reset, round-robin write-port sharing and a busy scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_sched
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = regfile_pkg::XLEN,
    parameter int RADDR_W = regfile_pkg::RADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*RADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]    req_data,
    input  logic                       alloc_valid,
    input  logic [RADDR_W-1:0]         alloc_rd,
    output logic                       alloc_ready,
    input  logic [RADDR_W-1:0]         rs1,
    input  logic [RADDR_W-1:0]         rs2,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    input  logic                       flush,
    output logic                       init_done,
    output logic                       wr_en,
    output logic [31:0]                rd,
    output logic [XLEN-1:0]            rd_value
);

    localparam logic [RADDR_W-1:0] c_last_reg = RADDR_W'(NUM_REGS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [RADDR_W-1:0]    r_cnt;
    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_nxt;
    logic                  r_wr_en;
    logic [RADDR_W-1:0]    r_rd;
    logic [XLEN-1:0]       r_rd_value;
    logic                  w_run;
    logic                  w_init_wr;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_any_grant;
    logic [RADDR_W-1:0]    w_sel_rd;
    logic [XLEN-1:0]       w_sel_data;
    logic                  w_alloc_fire;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_cnt == c_last_reg) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_run     = (r_state == ST_RUN);
        w_init_wr = (r_state == ST_INIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= RADDR_W'(1);
        end else if (w_init_wr) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ---------------- Arbitration ----------------
    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (w_run),
        .req   (req_valid),
        .grant (w_grant)
    );

    assign w_any_grant = |w_grant;
    assign req_ready   = w_grant;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = req_rd[i*RADDR_W +: RADDR_W];
                w_sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Writes to x0 are accepted from the requester but never reach the file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en    <= 1'b0;
            r_rd       <= '0;
            r_rd_value <= '0;
        end else if (w_init_wr) begin
            r_wr_en    <= 1'b1;
            r_rd       <= r_cnt;
            r_rd_value <= '0;
        end else if (w_any_grant) begin
            r_wr_en    <= (w_sel_rd != '0);
            r_rd       <= w_sel_rd;
            r_rd_value <= w_sel_data;
        end else begin
            r_wr_en    <= 1'b0;
        end
    end

    assign wr_en    = r_wr_en;
    assign rd       = {{(32-RADDR_W){1'b0}}, r_rd};
    assign rd_value = r_rd_value;
    assign init_done = w_run;

    // ---------------- Scoreboard ----------------
    assign alloc_ready  = w_run && !r_busy[alloc_rd];
    assign w_alloc_fire = alloc_valid && alloc_ready;
    assign rs1_busy     = r_busy[rs1];
    assign rs2_busy     = r_busy[rs2];

    // A new claim is applied after the retiring write's clear so it wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (r_wr_en) begin
                w_busy_nxt[r_rd] = 1'b0;
            end
            if (w_alloc_fire && (alloc_rd != '0)) begin
                w_busy_nxt[alloc_rd] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
// ============================================================================
// Module : tb_regfile_wb_sched
// Brief  : Directed self-checking bench for regfile_wb_sched.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_sched;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*RADDR_W-1:0] req_rd = '0;
    logic [NUM_REQ*XLEN-1:0]    req_data = '0;
    logic                       alloc_valid = 1'b0;
    logic [RADDR_W-1:0]         alloc_rd = '0;
    logic                       alloc_ready;
    logic [RADDR_W-1:0]         rs1 = '0;
    logic [RADDR_W-1:0]         rs2 = '0;
    logic                       rs1_busy;
    logic                       rs2_busy;
    logic                       flush = 1'b0;
    logic                       init_done;
    logic                       wr_en;
    logic [31:0]                rd;
    logic [XLEN-1:0]            rd_value;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_sched #(
        .NUM_REQ (NUM_REQ),
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .alloc_ready (alloc_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .flush       (flush),
        .init_done   (init_done),
        .wr_en       (wr_en),
        .rd          (rd),
        .rd_value    (rd_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
        req_rd[i*RADDR_W +: RADDR_W] = r;
        req_data[i*XLEN +: XLEN]     = d;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] exp_ready [4];
        logic [4:0] exp_rd    [4];
        logic [31:0] exp_dat  [4];

        // ---------------- Reset state, with requests pending ----------------
        req_valid   = 3'b111;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd3;
        #2 rst = 1'b1;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd", rd, 0);
        chk("rst_rd_value", rd_value, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_alloc_ready", alloc_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- Zero-fill sequence ----------------
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            chk("init_wr_en", wr_en, 1);
            chk("init_rd", rd, 64'(k));
            chk("init_rd_value", rd_value, 0);
            if (k <= 30) begin
                chk("init_done_low", init_done, 0);
                chk("init_req_ready", req_ready, 0);
                chk("init_alloc_ready", alloc_ready, 0);
            end
            if (k == 30) begin
                req_valid   = '0;
                alloc_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("init_done_high", init_done, 1);
        chk("post_init_wr_en", wr_en, 0);
        rs1 = 5'd3;
        #1 chk("init_claim_ignored", rs1_busy, 0);

        // ---------------- Round-robin, all three requesting ----------------
        set_req(0, 5'd10, 32'h0000_0100);
        set_req(1, 5'd11, 32'h0000_0111);
        set_req(2, 5'd12, 32'h0000_0222);
        req_valid = 3'b111;
        exp_ready = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_rd    = '{5'd10, 5'd11, 5'd12, 5'd10};
        exp_dat   = '{32'h100, 32'h111, 32'h222, 32'h100};
        for (int c = 0; c < 4; c++) begin
            #1 chk("rr_grant", req_ready, exp_ready[c]);
            @(negedge clk);
            chk("rr_wr_en", wr_en, 1);
            chk("rr_rd", rd, exp_rd[c]);
            chk("rr_data", rd_value, exp_dat[c]);
        end
        req_valid = '0;
        @(negedge clk);
        chk("idle_wr_en", wr_en, 0);

        // ---------------- Scoreboard: claim, WAW stall, clear ----------------
        alloc_valid = 1'b1;
        alloc_rd    = 5'd5;
        rs1         = 5'd5;
        #1;
        chk("alloc5_ready", alloc_ready, 1);
        chk("rs1_5_free", rs1_busy, 0);
        @(negedge clk);
        chk("rs1_5_busy", rs1_busy, 1);
        chk("alloc5_waw_stall", alloc_ready, 0);
        alloc_valid = 1'b0;
        set_req(1, 5'd5, 32'h0000_0055);
        req_valid = 3'b010;
        #1 chk("wb5_grant", req_ready, 3'b010);
        @(negedge clk);
        chk("wb5_wr_en", wr_en, 1);
        chk("wb5_rd", rd, 5);
        chk("wb5_data", rd_value, 32'h55);
        chk("wb5_still_busy", rs1_busy, 1);
        req_valid   = '0;
        alloc_valid = 1'b1;
        #1 chk("alloc5_same_cycle_clear", alloc_ready, 0);
        @(negedge clk);
        chk("rs1_5_cleared", rs1_busy, 0);
        chk("alloc5_ready_again", alloc_ready, 1);
        alloc_valid = 1'b0;

        // ---------------- x0 write and claim ----------------
        set_req(0, 5'd0, 32'hDEAD_BEEF);
        req_valid   = 3'b001;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd0;
        rs1         = 5'd0;
        #1;
        chk("x0_req_ready", req_ready, 3'b001);
        chk("x0_alloc_ready", alloc_ready, 1);
        @(negedge clk);
        chk("x0_no_write", wr_en, 0);
        chk("x0_never_busy", rs1_busy, 0);
        req_valid   = '0;
        alloc_valid = 1'b0;

        // ---------------- Flush beats simultaneous claim ----------------
        alloc_valid = 1'b1;
        alloc_rd = 5'd3; @(negedge clk);
        alloc_rd = 5'd7; @(negedge clk);
        alloc_rd = 5'd9; @(negedge clk);
        rs1 = 5'd3; rs2 = 5'd7;
        #1;
        chk("busy3", rs1_busy, 1);
        chk("busy7", rs2_busy, 1);
        rs1 = 5'd9;
        #1 chk("busy9", rs1_busy, 1);
        alloc_rd = 5'd12;
        flush    = 1'b1;
        #1 chk("flush_alloc12_ready", alloc_ready, 1);
        @(negedge clk);
        flush       = 1'b0;
        alloc_valid = 1'b0;
        rs1 = 5'd3; rs2 = 5'd7;
        #1;
        chk("flush_busy3", rs1_busy, 0);
        chk("flush_busy7", rs2_busy, 0);
        rs1 = 5'd9; rs2 = 5'd12;
        #1;
        chk("flush_busy9", rs1_busy, 0);
        chk("flush_busy12", rs2_busy, 0);

        // ---------------- Reset mid-RUN with a pending write ----------------
        @(negedge clk);
        set_req(0, 5'd20, 32'h0000_0077);
        req_valid   = 3'b001;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd20;
        rs1         = 5'd20;
        @(negedge clk);
        req_valid   = '0;
        alloc_valid = 1'b0;
        chk("pend_wr_en", wr_en, 1);
        chk("pend_rd", rd, 20);
        chk("pend_busy20", rs1_busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_rd", rd, 0);
        chk("mid_rst_busy", rs1_busy, 0);
        chk("mid_rst_init_done", init_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_wr_en", wr_en, 1);
        chk("restart_rd1", rd, 1);
        @(negedge clk);
        chk("restart_rd2", rd, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
